// File: rtl/mac_ctrl.sv
// Sequencer for a MAC fed by two 1-cycle-latency operand memories: walks the address,
// gates the accumulator clear, then scales and saturates the dot product into result.
// Optional MAC_CTRL_RELU_EN clamps negative results to zero.
module mac_ctrl #(
    parameter int LEN   = 16,
    parameter int SHIFT = 7,
    parameter int AW    = $clog2(LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [25:0]   acc,
    output logic [AW-1:0]        addr,
    output logic                 clr_n,
    output logic                 busy,
    output logic                 done,
    output logic signed [7:0]    result
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ACC   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CAPT  = 3'd4;

    localparam logic [AW-1:0] ADDR_LAST = AW'(LEN - 1);

    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              done_q, done_d;
    logic signed [7:0] result_q, result_d;

    function automatic logic signed [7:0] post_proc(input logic signed [25:0] a);
        logic signed [25:0] v;
        v = a >>> SHIFT;
        if (v > 26'sd127) return 8'sd127;
`ifdef MAC_CTRL_RELU_EN
        if (v < 26'sd0) return 8'sd0;
`else
        if (v < -26'sd128) return -8'sd128;
`endif
        return v[7:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start) state_d = S_FILL;
            end
            S_FILL: begin
                addr_d  = AW'(1);
                state_d = S_ACC;
            end
            S_ACC: begin
                // Address saturates at the last element; DRAIN reuses it.
                if (addr_q == ADDR_LAST) state_d = S_DRAIN;
                else                     addr_d  = addr_q + 1'b1;
            end
            S_DRAIN: state_d = S_CAPT;
            S_CAPT: begin
                result_d = post_proc(acc);
                done_d   = 1'b1;
                addr_d   = '0;
                state_d  = S_IDLE;
            end
            default: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign addr   = addr_q;
    assign clr_n  = (state_q == S_ACC) || (state_q == S_DRAIN);
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// Bench for mac_ctrl with LEN=4, SHIFT=7: bench-side MAC and operand memories,
// reference result computed directly from the operand arrays.
module tb_mac_ctrl;

    localparam int LEN   = 4;
    localparam int SHIFT = 7;
    localparam int AW    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [25:0]   mac_acc;
    logic [AW-1:0]        addr;
    logic                 clr_n;
    logic                 busy;
    logic                 done;
    logic signed [7:0]    result;

    logic signed [7:0]    mem_a [LEN];
    logic signed [7:0]    mem_b [LEN];
    logic signed [7:0]    rd_a, rd_b;
    logic signed [25:0]   prod;

    int n_cmp = 0;
    int n_err = 0;

    mac_ctrl #(.LEN(LEN), .SHIFT(SHIFT), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .acc    (mac_acc),
        .addr   (addr),
        .clr_n  (clr_n),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_a <= mem_a[addr];
        rd_b <= mem_b[addr];
    end

    assign prod = rd_a * rd_b;

    always @(posedge clk) begin
        if (!clr_n) mac_acc <= '0;
        else        mac_acc <= mac_acc + prod;
    end

    function automatic logic signed [7:0] ref_result();
        longint s = 0;
        longint v;
        for (int i = 0; i < LEN; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
        v = s >>> SHIFT;
        if (v > 127) return 8'sd127;
`ifdef MAC_CTRL_RELU_EN
        if (v < 0) return 8'sd0;
`else
        if (v < -128) return -8'sd128;
`endif
        return 8'(v);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input logic signed [7:0] a, input logic signed [7:0] b);
        for (int i = 0; i < LEN; i++) begin
            mem_a[i] = a;
            mem_b[i] = b;
        end
    endtask

    // One operation from IDLE; a start pulse is injected mid-operation and must be ignored.
    task automatic run_op(input string tag, input logic signed [7:0] exp_res);
        int exp_addr [6] = '{0, 0, 1, 2, 3, 3};
        int hi = 0;
        bit got = 1'b0;
        @(negedge clk);
        check({tag, "_idle_addr"}, addr, exp_addr[0]);
        check({tag, "_idle_busy"}, busy, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (clr_n) hi++;
            if (k <= 5) check($sformatf("%s_addr%0d", tag, k), addr, exp_addr[k]);
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            if (done) begin
                got = 1'b1;
                check({tag, "_latency"}, k, LEN + 3);
            end
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_clrn_cycles"}, hi, LEN);
        check({tag, "_result"}, result, exp_res);
        @(negedge clk);
        check({tag, "_after_busy"}, busy, 0);
        check({tag, "_after_done"}, done, 0);
    endtask

    initial begin
        fill_mem(8'sd0, 8'sd0);
        repeat (2) @(negedge clk);
        check("rst_addr", addr, 0);
        check("rst_clrn", clr_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        @(negedge clk);

        fill_mem(8'sd64, 8'sd2);
        run_op("basic", 8'sd4);

        fill_mem(8'sd64, 8'sd64);
        run_op("possat", 8'sd127);

`ifdef MAC_CTRL_RELU_EN
        fill_mem(-8'sd128, 8'sd127);
        run_op("negsat", 8'sd0);
        fill_mem(-8'sd64, 8'sd2);
        run_op("neg4", 8'sd0);
`else
        fill_mem(-8'sd128, 8'sd127);
        run_op("negsat", -8'sd128);
        fill_mem(-8'sd64, 8'sd2);
        run_op("neg4", -8'sd4);
`endif

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < LEN; i++) begin
                mem_a[i] = 8'($urandom_range(0, 255));
                mem_b[i] = 8'($urandom_range(0, 255));
            end
            run_op($sformatf("rand%0d", r), ref_result());
        end

        // start held high: a new operation every LEN+3 cycles.
        begin
            int ndone = 0;
            fill_mem(8'sd64, 8'sd2);
            @(negedge clk);
            start = 1'b1;
            for (int k = 1; k <= 34; k++) begin
                @(negedge clk);
                if (done) begin
                    ndone++;
                    check($sformatf("b2b_done_at%0d", ndone), k, ndone * (LEN + 3));
                    check($sformatf("b2b_result%0d", ndone), result, ref_result());
                end
                if (k == 22) start = 1'b0;
            end
            check("b2b_done_count", ndone, 4);
        end

        // Reset during ACC abandons the operation.
        begin
            int ndone = 0;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (3) @(negedge clk);
            check("mid_clrn_before_rst", clr_n, 1);
            rst = 1'b1;
            @(negedge clk);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_result", result, 0);
            check("mid_rst_done", done, 0);
            check("mid_rst_clrn", clr_n, 0);
            check("mid_rst_addr", addr, 0);
            rst = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done) ndone++;
            end
            check("mid_rst_no_done", ndone, 0);
            run_op("post_rst", 8'sd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
